// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        RECOVER
    } rx_state_e;

endpackage

// File: rtl/uart_byte_rx_if.sv
// rtl/uart_byte_rx_if.sv - byte/strobe bundle from the UART receiver to the packet parser
interface uart_byte_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data_out;
    logic                      data_rdy;
    logic                      frame_err;
    logic                      parity_err;
    logic                      busy;

    modport master (output data_out, data_rdy, frame_err, parity_err, busy);
    modport slave  (input  data_out, data_rdy, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - up-counting bit timer with full/half-bit terminal tick
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic half_i,
    output logic tick_o
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] FULL_TERM = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] HALF_TERM = W'((CLKS_PER_BIT / 2) - 1);

    logic [W-1:0] tmr_q, tmr_d;

    always_comb begin
        tick_o = (tmr_q == (half_i ? HALF_TERM : FULL_TERM));
        tmr_d  = (clr_i || tick_o) ? '0 : tmr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmr_q <= '0;
        else        tmr_q <= tmr_d;
    end
endmodule

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART byte receiver; define UART_RX_PARITY_EN for 8E1 with parity check
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    uart_byte_rx_if.master        rx_if
);
    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      rx_s;
    rx_state_e                 state_q, state_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
    logic                      rdy_q, rdy_d, ferr_q, ferr_d, perr_q, perr_d;
    logic                      busy_q, busy_d, par_bad_q, par_bad_d;
    logic                      tmr_clr, tmr_half, tick;

    assign rx_s = sync_q[SYNC_STAGES-1];

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tmr_clr),
        .half_i (tmr_half),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        data_d    = data_q;
        par_bad_d = par_bad_q;
        rdy_d     = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        tmr_clr   = 1'b0;
        tmr_half  = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_clr   = 1'b1;
                idx_d     = '0;
                par_bad_d = 1'b0;
                if (!rx_s) state_d = START;
            end
            START: begin
                tmr_half = 1'b1;
                if (tick) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    sh_d  = {rx_s, sh_q[UART_DATA_BITS-1:1]};
                    idx_d = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'(UART_DATA_BITS - 1)) state_d = PARITY;
`else
                    if (idx_q == 3'(UART_DATA_BITS - 1)) state_d = STOP;
`endif
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                // even parity: data bits plus parity bit must XOR to zero
                if (tick) begin
                    par_bad_d = rx_s ^ (^sh_q);
                    state_d   = STOP;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                // leaving at mid-stop-bit leaves half a bit to catch the next start edge
                if (tick) begin
                    perr_d = par_bad_q;
                    if (rx_s) begin
                        state_d = IDLE;
                        if (!par_bad_q) begin
                            data_d = sh_q;
                            rdy_d  = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RECOVER;
                    end
                end
            end
            RECOVER: begin
                tmr_clr = 1'b1;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            state_q   <= IDLE;
            idx_q     <= '0;
            sh_q      <= '0;
            data_q    <= '0;
            rdy_q     <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            busy_q    <= 1'b0;
            par_bad_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
            state_q   <= state_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            busy_q    <= busy_d;
            par_bad_q <= par_bad_d;
        end
    end

    assign rx_if.data_out   = data_q;
    assign rx_if.data_rdy   = rdy_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.parity_err = perr_q;
    assign rx_if.busy       = busy_q;
endmodule
